mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port, synchronous-read unified memory between the IF stage (instruction fetch) and the MEM stage (load/store). It sits between the pipeline and the unified memory array. It issues at most one memory access per cycle and routes each 1-cycle-latency response back to its owner. It also detects misaligned data accesses and bounds IF starvation with a counter.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/starve_counter.sv | 41 ++++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory path: access-type encodings,
// response owner tags and the data-access alignment rule.
package mem_pkg;

  typedef enum logic [2:0] {
    DM_WORD  = 3'b000,
    DM_HALF  = 3'b001,
    DM_HALFU = 3'b010,
    DM_BYTE  = 3'b011,
    DM_BYTEU = 3'b100
  } dm_type_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // Words need addr[1:0] == 0, halves need addr[0] == 0, bytes are always aligned.
  function automatic logic is_misaligned(input logic [2:0] typ, input logic [1:0] lsb);
    logic mis;
    mis = 1'b0;
    case (typ)
      DM_WORD:           mis = (lsb != 2'b00);
      DM_HALF, DM_HALFU: mis = lsb[0];
      default:           mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating counter of consecutive cycles a requester was refused.
// Counts while inc_i is high, otherwise returns to zero; never exceeds LIMIT.
module starve_counter #(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_limit_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: saturating increment while refused, clear otherwise.
  always_comb begin
    cnt_d = '0;
    if (inc_i) begin
      if (cnt_q == CNT_W'(LIMIT)) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign at_limit_o = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port, 1-cycle-latency memory
// between instruction fetch (IF) and load/store (DM). Misaligned DM accesses
// are answered with an error without touching memory, leaving the port to IF.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_type,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  output logic              dm_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_type,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  logic             dm_mis;
  logic             dm_aligned;
  logic             if_win;
  logic             dm_mem;
  logic             at_limit;
  logic [CNT_W-1:0] starve_cnt;

  logic   rsp_vld_q,   rsp_vld_d;
  owner_e rsp_owner_q, rsp_owner_d;
  logic   rsp_mem_q,   rsp_mem_d;
  logic   rsp_we_q,    rsp_we_d;
  logic   rsp_err_q,   rsp_err_d;
  logic   rsp_err2_q,  rsp_err2_d;
  logic   dm_own;

  starve_counter #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_starve (
    .clk        (clk),
    .rstn       (rstn),
    .inc_i      (if_req && !if_gnt),
    .cnt_o      (starve_cnt),
    .at_limit_o (at_limit)
  );

  // Grant decision: DM owns an aligned conflict unless IF has starved to the limit;
  // a misaligned DM never needs the port, so it is granted alongside anything.
  always_comb begin
    dm_mis     = dm_req && is_misaligned(dm_type, dm_addr[1:0]);
    dm_aligned = dm_req && !dm_mis;
    if_win     = rstn && if_req && (!dm_aligned || at_limit);
    dm_mem     = rstn && dm_aligned && !if_win;
    if_gnt     = if_win;
    dm_gnt     = rstn && dm_req && (dm_mis || !if_win);
  end

  // Memory port drive; all fields idle at zero when no access is issued.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_type  = DM_WORD;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_win) begin
      mem_en   = 1'b1;
      mem_addr = if_addr & WORD_MASK;
    end else if (dm_mem) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_type  = dm_type;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end
  end

  // Describe the response owed next cycle; a misaligned DM riding with an IF
  // fetch goes in the secondary error flag so both can answer together.
  always_comb begin
    rsp_vld_d   = if_win || dm_gnt;
    rsp_owner_d = if_win ? OWN_IF : OWN_DM;
    rsp_mem_d   = if_win || dm_mem;
    rsp_we_d    = dm_mem && dm_we;
    rsp_err_d   = dm_gnt && dm_mis && !if_win;
    rsp_err2_d  = dm_gnt && dm_mis && if_win;
  end

  // Response tracking registers; reset drops any in-flight response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_vld_q   <= 1'b0;
      rsp_owner_q <= OWN_IF;
      rsp_mem_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_err2_q  <= 1'b0;
    end else begin
      rsp_vld_q   <= rsp_vld_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_mem_q   <= rsp_mem_d;
      rsp_we_q    <= rsp_we_d;
      rsp_err_q   <= rsp_err_d;
      rsp_err2_q  <= rsp_err2_d;
    end
  end

  // Route the memory response to its owner; stores and errors return zero data.
  always_comb begin
    dm_own    = rsp_vld_q && (rsp_owner_q == OWN_DM);
    if_rvalid = rsp_vld_q && (rsp_owner_q == OWN_IF);
    dm_rvalid = dm_own || rsp_err2_q;
    dm_err    = (dm_own && rsp_err_q) || rsp_err2_q;
    if_rdata  = (if_rvalid && rsp_mem_q) ? mem_rdata : 32'h0;
    dm_rdata  = (dm_own && rsp_mem_q && !rsp_we_q) ? mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vectors with literal
// expectations plus a cycle-by-cycle behavioural model of the arbiter.
module tb_mem_arbiter;

  localparam int unsigned LIM = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [2:0]  dm_type = '0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_gnt, dm_rvalid, dm_err;
  logic [31:0] dm_rdata;
  logic        mem_en, mem_we;
  logic [2:0]  mem_type;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  int nchk = 0;
  int nerr = 0;

  mem_arbiter #(.STARVE_LIMIT(LIM), .ADDR_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_type(dm_type), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_type(mem_type), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory content pattern: read data is the address with its two low bits flipped.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h0000_0003;
  endfunction

  // Memory stand-in: 1-cycle read latency, junk on the bus when nothing was read.
  always @(posedge clk) begin
    mem_rdata <= (mem_en && !mem_we) ? pat(mem_addr) : 32'hA5A5_5A5A;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Alignment rule stated as size divisibility.
  function automatic logic m_mis(input logic [2:0] t, input logic [31:0] a);
    int unsigned sz;
    case (t)
      3'd0:       sz = 4;
      3'd1, 3'd2: sz = 2;
      default:    sz = 1;
    endcase
    return (a % sz) != 0;
  endfunction

  // Model state: starvation count and the response owed next cycle.
  int unsigned starve_m = 0;
  logic        p_if_rv = 0, p_dm_rv = 0, p_dm_err = 0;
  logic [31:0] p_if_d = '0, p_dm_d = '0;

  always @(negedge clk) begin
    logic mis, al, e_if, e_dm, e_mem, dmem;
    logic [31:0] e_addr;
    if (!rstn) begin
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_dm_gnt", dm_gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_dm_rvalid", dm_rvalid, 0);
      chk("rst_dm_err", dm_err, 0);
      starve_m = 0; p_if_rv = 0; p_dm_rv = 0; p_dm_err = 0; p_if_d = 0; p_dm_d = 0;
    end else begin
      mis  = dm_req && m_mis(dm_type, dm_addr);
      al   = dm_req && !mis;
      e_if = (if_req && al) ? (starve_m == LIM) : if_req;
      e_dm = dm_req && (mis || !e_if);
      dmem = al && e_dm;
      e_mem = e_if || dmem;
      e_addr = e_if ? {if_addr[31:2], 2'b00} : (dmem ? dm_addr : 32'h0);
      chk("m_if_gnt", if_gnt, e_if);
      chk("m_dm_gnt", dm_gnt, e_dm);
      chk("m_mem_en", mem_en, e_mem);
      chk("m_mem_we", mem_we, dmem && dm_we);
      chk("m_mem_type", mem_type, dmem ? dm_type : 3'd0);
      chk("m_mem_addr", mem_addr, e_addr);
      chk("m_mem_wdata", mem_wdata, dmem ? dm_wdata : 32'h0);
      chk("m_if_rvalid", if_rvalid, p_if_rv);
      chk("m_if_rdata", if_rdata, p_if_d);
      chk("m_dm_rvalid", dm_rvalid, p_dm_rv);
      chk("m_dm_err", dm_err, p_dm_err);
      chk("m_dm_rdata", dm_rdata, p_dm_d);
      p_if_rv  = e_if;
      p_if_d   = e_if ? pat({if_addr[31:2], 2'b00}) : 32'h0;
      p_dm_rv  = e_dm;
      p_dm_err = e_dm && mis;
      p_dm_d   = (dmem && !dm_we) ? pat(dm_addr) : 32'h0;
      if (if_req && !e_if) starve_m = (starve_m < LIM) ? starve_m + 1 : starve_m;
      else starve_m = 0;
    end
  end

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic we,
                       input logic [2:0] dt, input logic [31:0] da, input logic [31:0] dw);
    @(posedge clk); #1;
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = we; dm_type = dt; dm_addr = da; dm_wdata = dw;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    // Reset state with a request already pending on the input.
    if_req = 1'b1; if_addr = 32'h40;
    #2;
    chk("init_if_gnt", if_gnt, 0);
    chk("init_mem_en", mem_en, 0);
    chk("init_starve", dut.starve_cnt, 0);
    idle();
    @(posedge clk); #1; rstn = 1'b1;
    idle();

    // Single fetch.
    drive(1, 32'h10, 0, 0, 0, 0, 0); settle();
    chk("fetch_gnt", if_gnt, 1);
    chk("fetch_mem_addr", mem_addr, 32'h10);
    chk("fetch_mem_type", mem_type, 0);
    idle(); settle();
    chk("fetch_rvalid", if_rvalid, 1);
    chk("fetch_rdata", if_rdata, 32'h13);

    // Reset mid-access: granted at N, reset at N+0.5, nothing at N+1.
    drive(1, 32'h40, 0, 0, 0, 0, 0); settle();
    chk("rma_gnt", if_gnt, 1);
    rstn = 1'b0; #1;
    chk("rma_if_gnt_low", if_gnt, 0);
    chk("rma_mem_en_low", mem_en, 0);
    settle();
    chk("rma_no_rvalid", if_rvalid, 0);
    chk("rma_no_rdata", if_rdata, 0);
    @(posedge clk); #1; rstn = 1'b1; if_req = 1'b0;
    settle();
    chk("rma_post_rvalid", if_rvalid, 0);

    // Conflict: DM store wins.
    drive(1, 32'h30, 1, 1, 3'd0, 32'h100, 32'hDEADBEEF); settle();
    chk("cf_dm_gnt", dm_gnt, 1);
    chk("cf_if_gnt", if_gnt, 0);
    chk("cf_mem_we", mem_we, 1);
    chk("cf_mem_wdata", mem_wdata, 32'hDEADBEEF);
    idle(); settle();
    chk("cf_dm_rvalid", dm_rvalid, 1);
    chk("cf_dm_rdata", dm_rdata, 0);
    chk("cf_dm_err", dm_err, 0);

    // Starvation: IF refused four times, wins the fifth, then DM again.
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h30, 1, 1, 3'd0, 32'h100, 32'hDEADBEEF); settle();
      chk("sv_if_gnt", if_gnt, (i == 4) ? 1 : 0);
      chk("sv_dm_gnt", dm_gnt, (i == 4) ? 0 : 1);
      if (i == 5) chk("sv_cnt_clr", dut.starve_cnt, 0);
    end
    // Dropping if_req clears the count: four more refusals needed.
    drive(0, 32'h30, 1, 0, 3'd0, 32'h104, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h34, 1, 0, 3'd0, 32'h108, 0); settle();
      chk("sv2_if_gnt", if_gnt, (i == 4) ? 1 : 0);
    end

    // Misaligned word DM alongside a fetch.
    idle();
    drive(1, 32'h20, 1, 0, 3'd0, 32'h102, 0); settle();
    chk("mis_if_gnt", if_gnt, 1);
    chk("mis_dm_gnt", dm_gnt, 1);
    chk("mis_mem_addr", mem_addr, 32'h20);
    chk("mis_mem_we", mem_we, 0);
    idle(); settle();
    chk("mis_if_rvalid", if_rvalid, 1);
    chk("mis_if_rdata", if_rdata, 32'h23);
    chk("mis_dm_rvalid", dm_rvalid, 1);
    chk("mis_dm_err", dm_err, 1);
    chk("mis_dm_rdata", dm_rdata, 0);

    // Half-word alignment: 0x102 goes to memory, 0x103 errors.
    drive(0, 0, 1, 0, 3'd1, 32'h102, 0); settle();
    chk("hw_ok_mem_en", mem_en, 1);
    chk("hw_ok_type", mem_type, 3'd1);
    drive(0, 0, 1, 0, 3'd1, 32'h103, 0); settle();
    chk("hw_ok_err", dm_err, 0);
    chk("hw_ok_rdata", dm_rdata, 32'h101);
    chk("hw_bad_mem_en", mem_en, 0);
    chk("hw_bad_gnt", dm_gnt, 1);
    idle(); settle();
    chk("hw_bad_rvalid", dm_rvalid, 1);
    chk("hw_bad_err", dm_err, 1);

    // Byte loads never misalign; half-unsigned at an odd address does.
    drive(0, 0, 1, 0, 3'd4, 32'h203, 0); settle();
    chk("by_mem_en", mem_en, 1);
    drive(0, 0, 1, 1, 3'd2, 32'h201, 32'h1234); settle();
    chk("hu_mem_en", mem_en, 0);
    chk("by_rdata", dm_rdata, 32'h200);
    idle(); settle();
    chk("hu_err", dm_err, 1);
    idle(); idle();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
